pc_src_stack: RTL and testbench
===============================

# pc_src_stack

Next-address source for the RAT program counter: drives the counter's `DIN` load value each cycle and owns a dedicated return-address stack for CALL/RET. The control unit selects the source and issues push/pop strobes. The program counter loads `DIN` when the control unit asserts its load. All stack state is local, so CALL/RET do not consume scratch-RAM cycles.

## Interface
- `n`, 10, address width; matches program counter width.
- `DEPTH`, 8, return-stack entries; power of two, at least 2.
- `ISR_VEC`, 10'h3FF, interrupt vector address (n bits).

- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `PC_COUNT`  in  n  current program counter value.
- `IR_ADDR`  in  n  branch/call target field from the instruction.
- `PC_MUX_SEL`  in  2  next-address source: 0 = `IR_ADDR`, 1 = stack top, 2 = `ISR_VEC`, 3 = zero.
- `PUSH`  in  1  push return address (CALL, interrupt entry).
- `POP`  in  1  pop return address (RET, RETIE/RETID).
- `CLR_ERR`  in  1  clears sticky `ERR`.
- `DIN`  out  n  load value presented to the program counter.
- `EMPTY`  out  1  no valid entries.
- `FULL`  out  1  `DEPTH` valid entries.
- `LEVEL`  out  $clog2(DEPTH+1)  number of valid entries.
- `ERR`  out  1  sticky overflow/underflow flag.

## Operation
- `DIN` is combinational from `PC_MUX_SEL`:
  - Select 1 outputs the current top entry. It outputs 0 when `EMPTY`.
  - Select 3 outputs 0.
- Push value is `PC_COUNT + 1`, truncated to n bits. `PC_COUNT` = 2^n−1 therefore pushes 0.
- `PUSH` only, not full: write to `mem[LEVEL]`, `LEVEL` +1.
- `PUSH` only, full: no write, `LEVEL` unchanged, `ERR` set (overflow).
- `POP` only, not empty: `LEVEL` −1. The top value was already on `DIN` during the pop cycle.
- `POP` only, empty: `LEVEL` stays 0, `ERR` set (underflow).
- `PUSH` and `POP`, not empty: top entry overwritten with the push value, `LEVEL` unchanged, no error.
- `PUSH` and `POP`, empty: treated as a push (`LEVEL` becomes 1), `ERR` set.
- `ERR`:
  - Set by any error event.
  - Cleared by `CLR_ERR`.
  - A set and a clear in the same cycle leaves `ERR` = 1.
- `EMPTY` = (`LEVEL` == 0). `FULL` = (`LEVEL` == `DEPTH`). Both are decoded from the registered `LEVEL`.

## Timing
- Reset (`RST_N` low, asynchronous): `LEVEL` = 0, `EMPTY` = 1, `FULL` = 0, `ERR` = 0.
  - With `PC_MUX_SEL` = 3 or 1, `DIN` reads 0.
  - Stack memory is not cleared. Entries are unreadable until written.
- Reset asserted mid-operation discards all entries immediately, with no wait for `CLK`.
- Reset release is synchronised by the system reset tree, not inside this block.
- Zero-cycle latency from `PC_MUX_SEL` and the current top entry to `DIN`.
- Stack updates take effect at the next rising edge.
- A RET in cycle t presents the top entry on `DIN` in cycle t. The pop completes at the edge ending t.
- Push followed by pop in the next cycle returns the pushed value.
- Back-to-back pushes and pops at one per cycle are sustained with no bubbles.

## Structure
- Shared package `rat_pkg` holds:
  - `typedef enum logic [1:0] {PCSRC_IR, PCSRC_STK, PCSRC_ISR, PCSRC_ZERO} pc_src_t`.
  - Default `ISR_VEC` constant.
- One sub-module, `ras_lifo`: the parameterised LIFO (memory, `LEVEL` pointer, full/empty, error detection).
- The top level holds:
  - the source mux,
  - the return-address incrementer,
  - the sticky `ERR` register.

## Test plan
- Reset, then `PC_MUX_SEL` = 0 with `IR_ADDR` = 0x155 -> `DIN` = 0x155, `EMPTY` = 1, `LEVEL` = 0, `ERR` = 0.
- `PC_COUNT` = 0x020, `PUSH`, then `PC_COUNT` = 0x040, `PUSH`; then `POP` with sel = 1 twice -> `DIN` = 0x041, then 0x021; `EMPTY` = 1 after.
- 8 pushes -> `FULL` = 1; 9th push with `PC_COUNT` = 0x0AA -> `LEVEL` stays 8, `ERR` = 1, top unchanged; a `CLR_ERR` pulse -> `ERR` = 0.
- From empty, `POP` -> `ERR` = 1, `LEVEL` = 0, `DIN` (sel = 1) = 0. Simultaneous `POP` + `CLR_ERR` -> `ERR` stays 1.
- `LEVEL` = 2, simultaneous `PUSH` + `POP` with `PC_COUNT` = 0x3FF -> `LEVEL` = 2, top = 0x000, `ERR` = 0.
- `LEVEL` = 5, `RST_N` pulsed low between edges -> `LEVEL` = 0 and `EMPTY` = 1 before the next edge; sel = 2 -> `DIN` = 0x3FF.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared RAT datapath definitions: program-counter source encoding and the
// default interrupt vector.
package rat_pkg;

    typedef enum logic [1:0] {
        PCSRC_IR,
        PCSRC_STK,
        PCSRC_ISR,
        PCSRC_ZERO
    } pc_src_t;

    localparam logic [9:0] ISR_VEC_DEFAULT = 10'h3FF;

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: entry storage, occupancy pointer, full/empty decode
// and a one-cycle error strobe for overflow/underflow.
module ras_lifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 top,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign top_idx = AW'(level_q - LW'(1));
    assign top     = empty ? '0 : mem[top_idx];

    // A simultaneous push/pop on a non-empty stack replaces the top in place.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = AW'(level_q);
        level_nxt = level_q;
        err_evt   = 1'b0;
        if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                wr_idx    = '0;
                level_nxt = LW'(1);
                err_evt   = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (full) begin
                err_evt = 1'b1;
            end else begin
                wr_en     = 1'b1;
                level_nxt = level_q + LW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err_evt = 1'b1;
            end else begin
                level_nxt = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_src_stack.sv
// Next-address source for the program counter: source mux, return-address
// incrementer, sticky error flag and the local return-address stack.
module pc_src_stack
    import rat_pkg::*;
#(
    parameter int           n       = 10,
    parameter int           DEPTH   = 8,
    parameter logic [n-1:0] ISR_VEC = n'(ISR_VEC_DEFAULT)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [n-1:0]                 PC_COUNT,
    input  logic [n-1:0]                 IR_ADDR,
    input  logic [1:0]                   PC_MUX_SEL,
    input  logic                         PUSH,
    input  logic                         POP,
    input  logic                         CLR_ERR,
    output logic [n-1:0]                 DIN,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic                         ERR
);

    logic [n-1:0] ret_addr;
    logic [n-1:0] stk_top;
    logic         err_evt;
    logic         err_q;

    assign ret_addr = PC_COUNT + n'(1);

    ras_lifo #(
        .W     (n),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (PUSH),
        .pop     (POP),
        .wdata   (ret_addr),
        .top     (stk_top),
        .empty   (EMPTY),
        .full    (FULL),
        .level   (LEVEL),
        .err_evt (err_evt)
    );

    always_comb begin
        DIN = '0;
        case (pc_src_t'(PC_MUX_SEL))
            PCSRC_IR:   DIN = IR_ADDR;
            PCSRC_STK:  DIN = stk_top;
            PCSRC_ISR:  DIN = ISR_VEC;
            PCSRC_ZERO: DIN = '0;
            default:    DIN = '0;
        endcase
    end

    // A new error wins over a clear arriving in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end else if (CLR_ERR) begin
            err_q <= 1'b0;
        end
    end

    assign ERR = err_q;

endmodule

// File: tb/tb_pc_src_stack.sv
// Scoreboard bench for pc_src_stack: directed test-plan sequences followed by
// random traffic, checked against a queue-based return-stack model.
module tb_pc_src_stack;

    logic       CLK;
    logic       RST_N;
    logic [9:0] PC_COUNT;
    logic [9:0] IR_ADDR;
    logic [1:0] PC_MUX_SEL;
    logic       PUSH;
    logic       POP;
    logic       CLR_ERR;
    logic [9:0] DIN;
    logic       EMPTY;
    logic       FULL;
    logic [3:0] LEVEL;
    logic       ERR;

    typedef struct {
        logic [9:0] din;
        logic [3:0] level;
        logic       empty;
        logic       full;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       expQ[$];
    logic [9:0] stk[$];
    logic       errM;
    int         cycNum;
    int         checks;
    int         passes;

    pc_src_stack dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PC_COUNT   (PC_COUNT),
        .IR_ADDR    (IR_ADDR),
        .PC_MUX_SEL (PC_MUX_SEL),
        .PUSH       (PUSH),
        .POP        (POP),
        .CLR_ERR    (CLR_ERR),
        .DIN        (DIN),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .LEVEL      (LEVEL),
        .ERR        (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic exp_t calcExpected(input logic [1:0] sel, input logic [9:0] ir);
        exp_t e;
        case (sel)
            2'd0:    e.din = ir;
            2'd1:    e.din = (stk.size() > 0) ? stk[stk.size()-1] : 10'h000;
            2'd2:    e.din = 10'h3FF;
            default: e.din = 10'h000;
        endcase
        e.level = 4'(stk.size());
        e.empty = (stk.size() == 0);
        e.full  = (stk.size() == 8);
        e.err   = errM;
        e.cyc   = cycNum;
        return e;
    endfunction

    task automatic modelUpdate(input logic [9:0] pc, input logic doPush, input logic doPop,
                               input logic clr);
        logic [9:0] pv;
        logic       errEvt;
        pv     = pc + 10'd1;
        errEvt = 1'b0;
        if (doPush && doPop) begin
            if (stk.size() > 0) begin
                void'(stk.pop_back());
            end else begin
                errEvt = 1'b1;
            end
            stk.push_back(pv);
        end else if (doPush) begin
            if (stk.size() < 8) stk.push_back(pv);
            else errEvt = 1'b1;
        end else if (doPop) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else errEvt = 1'b1;
        end
        if (errEvt) errM = 1'b1;
        else if (clr) errM = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [9:0] ir, input logic [9:0] pc,
                                 input logic doPush, input logic doPop, input logic clr);
        @(posedge CLK);
        #1;
        cycNum++;
        PC_MUX_SEL = sel;
        IR_ADDR    = ir;
        PC_COUNT   = pc;
        PUSH       = doPush;
        POP        = doPop;
        CLR_ERR    = clr;
        expQ.push_back(calcExpected(sel, ir));
        modelUpdate(pc, doPush, doPop, clr);
    endtask

    // Reset pulse lands entirely between two rising edges.
    task automatic pulseReset(input logic [1:0] sel);
        @(posedge CLK);
        #1;
        cycNum++;
        PC_MUX_SEL = sel;
        IR_ADDR    = 10'h000;
        PC_COUNT   = 10'h000;
        PUSH       = 1'b0;
        POP        = 1'b0;
        CLR_ERR    = 1'b0;
        RST_N      = 1'b0;
        #1;
        stk.delete();
        errM = 1'b0;
        expQ.push_back(calcExpected(sel, 10'h000));
        #1;
        RST_N = 1'b1;
    endtask

    task automatic compareField(input string name, input int cyc, input logic [9:0] act,
                                input logic [9:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("DIN",   e.cyc, DIN,          e.din);
        compareField("LEVEL", e.cyc, 10'(LEVEL),   10'(e.level));
        compareField("EMPTY", e.cyc, 10'(EMPTY),   10'(e.empty));
        compareField("FULL",  e.cyc, 10'(FULL),    10'(e.full));
        compareField("ERR",   e.cyc, 10'(ERR),     10'(e.err));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic       rp;
        logic       rq;
        logic       rc;
        logic [9:0] rpc;
        checks     = 0;
        passes     = 0;
        cycNum     = 0;
        errM       = 1'b0;
        RST_N      = 1'b0;
        PC_COUNT   = '0;
        IR_ADDR    = '0;
        PC_MUX_SEL = 2'd3;
        PUSH       = 1'b0;
        POP        = 1'b0;
        CLR_ERR    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        applyStimulus(2'd3, 10'h000, 10'h000, 0, 0, 0);
        applyStimulus(2'd0, 10'h155, 10'h000, 0, 0, 0);

        applyStimulus(2'd0, 10'h000, 10'h020, 1, 0, 0);
        applyStimulus(2'd0, 10'h000, 10'h040, 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 1, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 1, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);

        for (int i = 0; i < 8; i++) applyStimulus(2'd1, 10'h000, 10'(i * 16 + 3), 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h0AA, 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 1);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);

        for (int i = 0; i < 8; i++) applyStimulus(2'd1, 10'h000, 10'h000, 0, 1, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 1, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 1, 1);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 1);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);

        applyStimulus(2'd1, 10'h000, 10'h100, 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h200, 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h3FF, 1, 1, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);

        for (int i = 0; i < 3; i++) applyStimulus(2'd1, 10'h000, 10'(i + 7), 1, 0, 0);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);
        pulseReset(2'd2);
        applyStimulus(2'd1, 10'h000, 10'h000, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            rp  = ($urandom_range(0, 99) < 45);
            rq  = ($urandom_range(0, 99) < 40);
            rc  = ($urandom_range(0, 99) < 10);
            rpc = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
            applyStimulus(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), rpc, rp, rq, rc);
        end
        applyStimulus(2'd3, 10'h000, 10'h000, 0, 0, 0);

        repeat (3) @(posedge CLK);
        checks++;
        if (expQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
